prio_rr_arbiter: RTL and testbench

- Parametrised, registered successor to the 8-to-3 priority encoder.
- Encodes an N-bit request vector into a W-bit granted index plus a one-hot grant and a valid flag.
- Two modes, selectable at run time: fixed priority (highest index wins) and round-robin (rotating fairness pointer).
- Adds clock enable and grant lock; sits in front of shared ALU/datapath resources that several requesters contend for.

---
 rtl/prio_rr_arbiter_if.sv | 34 +++
 rtl/prio_rr_arbiter.sv | 98 +++++++++
 tb/tb_prio_rr_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/prio_rr_arbiter_if.sv
// Request/grant bundle for prio_rr_arbiter.
//   master : requester side, drives en/mode/lock/req, observes the grant.
//   slave  : arbiter side, observes controls/requests, drives the grant.
// Signals:
//   en        evaluation enable (0 freezes the arbiter)
//   mode      0 = fixed priority (MSB highest), 1 = round-robin
//   lock      hold the current grant while its requester stays asserted
//   req       N-bit request vector
//   grant_idx binary index of the granted requester
//   grant_oh  one-hot grant, zero when no grant is active
//   valid     a grant is active
interface prio_rr_arbiter_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned W = $clog2(N);

  logic         en;
  logic         mode;
  logic         lock;
  logic [N-1:0] req;
  logic [W-1:0] grant_idx;
  logic [N-1:0] grant_oh;
  logic         valid;

  modport master (
    output en, mode, lock, req,
    input  grant_idx, grant_oh, valid
  );

  modport slave (
    input  en, mode, lock, req,
    output grant_idx, grant_oh, valid
  );
endinterface

// File: rtl/prio_rr_arbiter.sv
// Registered N-way arbiter: fixed priority (highest index wins) or
// round-robin (rotating pointer), selectable per cycle, with clock enable
// and grant lock. Outputs update one cycle after req is sampled.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    prio_rr_arbiter_if.slave (en, mode, lock, req -> grant_idx,
//          grant_oh, valid)
module prio_rr_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  prio_rr_arbiter_if.slave   bus
);
  localparam int unsigned W = $clog2(N);

  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] oh_q, oh_d;
  logic         valid_q, valid_d;
  logic [W-1:0] last_q, last_d;

  logic [W-1:0] fp_idx;
  logic [W-1:0] rr_idx;
  logic         rr_found;
  logic [W-1:0] win_idx;
  logic         hold;

  // (base + off) mod N without a divider; off is at most N.
  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] base,
                                            input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N) s = s - N;
    return W'(s);
  endfunction

  // Fixed priority: the last set bit seen while scanning upward is the highest.
  always_comb begin
    fp_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (bus.req[i]) fp_idx = W'(i);
    end
  end

  // Round-robin: scan from last+1 around to last itself; first hit wins.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int unsigned off = 1; off <= N; off++) begin
      if (!rr_found && bus.req[wrap_add(last_q, off)]) begin
        rr_found = 1'b1;
        rr_idx   = wrap_add(last_q, off);
      end
    end
  end

  assign hold    = bus.lock && valid_q && bus.req[idx_q];
  assign win_idx = bus.mode ? rr_idx : fp_idx;

  always_comb begin
    idx_d   = idx_q;
    oh_d    = oh_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (bus.en && !hold) begin
      if (bus.req == '0) begin
        idx_d   = '0;
        oh_d    = '0;
        valid_d = 1'b0;
      end else begin
        idx_d   = win_idx;
        oh_d    = N'(1) << win_idx;
        valid_d = 1'b1;
        if (bus.mode) last_d = win_idx;
      end
    end
  end

  // last resets to N-1 so the first round-robin search begins at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      oh_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= W'(N - 1);
    end else begin
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign bus.grant_idx = idx_q;
  assign bus.grant_oh  = oh_q;
  assign bus.valid     = valid_q;
endmodule

// File: tb/tb_prio_rr_arbiter.sv
module tb_prio_rr_arbiter;
  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  prio_rr_arbiter_if #(.N(8)) bif ();

  prio_rr_arbiter #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic e_v,
                       input logic [2:0] e_idx, input logic [7:0] e_oh);
    n_assert++;
    assert ({bif.valid, bif.grant_idx, bif.grant_oh} === {e_v, e_idx, e_oh})
    else begin
      n_fail++;
      $error("FAIL %s: observed valid=%0b idx=%0d oh=%02h, expected valid=%0b idx=%0d oh=%02h",
             tag, bif.valid, bif.grant_idx, bif.grant_oh, e_v, e_idx, e_oh);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge: asserts reset mid-cycle, checks the
  // asynchronous clear, holds through an edge, releases after it.
  task automatic pulse_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    check({tag, "_async"}, 1'b0, 3'd0, 8'h00);
    tick();
    check({tag, "_held"}, 1'b0, 3'd0, 8'h00);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] v;
    logic [2:0] hi;

    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    bif.en   = 1'b1;
    bif.mode = 1'b0;
    bif.lock = 1'b0;
    bif.req  = 8'h00;

    #1 rst_n = 1'b0;
    #1 check("reset", 1'b0, 3'd0, 8'h00);
    tick();
    check("reset_edge", 1'b0, 3'd0, 8'h00);
    rst_n = 1'b1;
    tick();
    check("after_release", 1'b0, 3'd0, 8'h00);

    // Fixed-priority sweep over every request pattern.
    for (int r = 0; r < 256; r++) begin
      v = 8'(r);
      bif.req = v;
      tick();
      hi = 3'd0;
      for (int b = 0; b < 8; b++) if (v[b]) hi = 3'(b);
      if (v == 8'h00) check($sformatf("sweep_%02h", v), 1'b0, 3'd0, 8'h00);
      else            check($sformatf("sweep_%02h", v), 1'b1, hi, 8'h01 << hi);
    end
    bif.req = 8'h2C;
    tick();
    check("fixed_2c", 1'b1, 3'd5, 8'h20);

    // Round-robin fairness from a fresh pointer.
    pulse_reset("rst_rr");
    bif.mode = 1'b1;
    bif.req  = 8'hFF;
    tick(); check("rr_ff_0", 1'b1, 3'd0, 8'h01);
    tick(); check("rr_ff_1", 1'b1, 3'd1, 8'h02);
    tick(); check("rr_ff_2", 1'b1, 3'd2, 8'h04);
    tick(); check("rr_ff_3", 1'b1, 3'd3, 8'h08);
    tick(); check("rr_ff_4", 1'b1, 3'd4, 8'h10);
    tick(); check("rr_ff_5", 1'b1, 3'd5, 8'h20);
    tick(); check("rr_ff_6", 1'b1, 3'd6, 8'h40);
    tick(); check("rr_ff_7", 1'b1, 3'd7, 8'h80);
    tick(); check("rr_ff_wrap0", 1'b1, 3'd0, 8'h01);
    tick(); check("rr_ff_wrap1", 1'b1, 3'd1, 8'h02);

    // Skip and wrap.
    pulse_reset("rst_skip");
    bif.req = 8'h81;
    tick(); check("rr_81_a", 1'b1, 3'd0, 8'h01);
    tick(); check("rr_81_b", 1'b1, 3'd7, 8'h80);
    tick(); check("rr_81_c", 1'b1, 3'd0, 8'h01);
    tick(); check("rr_81_d", 1'b1, 3'd7, 8'h80);
    bif.req = 8'h04;
    tick(); check("rr_single_a", 1'b1, 3'd2, 8'h04);
    tick(); check("rr_single_b", 1'b1, 3'd2, 8'h04);
    tick(); check("rr_single_c", 1'b1, 3'd2, 8'h04);

    // Lock hold and release.
    pulse_reset("rst_lock");
    bif.req = 8'h0F;
    tick(); check("lock_pre0", 1'b1, 3'd0, 8'h01);
    tick(); check("lock_pre1", 1'b1, 3'd1, 8'h02);
    bif.lock = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(); check($sformatf("lock_hold_%0d", k), 1'b1, 3'd1, 8'h02);
    end
    bif.req = 8'h0D;
    tick(); check("lock_drop", 1'b1, 3'd2, 8'h04);
    bif.lock = 1'b0;
    bif.req  = 8'h0F;
    tick(); check("unlock_3", 1'b1, 3'd3, 8'h08);
    tick(); check("unlock_0", 1'b1, 3'd0, 8'h01);

    // Enable freeze, then mode switches with the pointer at 0.
    bif.en  = 1'b0;
    bif.req = 8'hF0;
    tick(); check("en0_a", 1'b1, 3'd0, 8'h01);
    bif.req = 8'h00;
    tick(); check("en0_b", 1'b1, 3'd0, 8'h01);
    bif.req = 8'hAA;
    bif.mode = 1'b0;
    tick(); check("en0_c", 1'b1, 3'd0, 8'h01);
    bif.en   = 1'b1;
    bif.mode = 1'b0;
    bif.req  = 8'h0F;
    tick(); check("mode_fixed", 1'b1, 3'd3, 8'h08);
    bif.mode = 1'b1;
    tick(); check("mode_rr_resume", 1'b1, 3'd1, 8'h02);

    // Async reset while granting index 6.
    bif.mode = 1'b0;
    bif.req  = 8'h40;
    tick(); check("pre_reset_6", 1'b1, 3'd6, 8'h40);
    pulse_reset("rst_mid");
    bif.mode = 1'b1;
    bif.req  = 8'hFF;
    tick(); check("post_reset_rr0", 1'b1, 3'd0, 8'h01);
    tick(); check("post_reset_rr1", 1'b1, 3'd1, 8'h02);
    bif.req = 8'h00;
    tick(); check("rr_idle", 1'b0, 3'd0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
